adder_test_seq: RTL

Self-checking stimulus sequencer and scoreboard for the 16-bit adder under test. On `start` it issues a fixed directed set followed by LFSR-random operand pairs to the adder, one per cycle. It computes the 17-bit reference sum for each pair, delays it to match the adder's pipeline latency, and compares it against the adder's result. It replaces the per-cycle compare-and-print checker with a sequenced run that ends in a pass/fail summary.

---
 rtl/adder_test_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/adder_test_seq.sv
// Stimulus sequencer and scoreboard for a pipelined 16-bit adder: issues directed then
// LFSR-random operand pairs, delays the reference sum by LATENCY and counts mismatches.
module adder_test_seq #(
    parameter int LATENCY     = 2,
    parameter int NUM_VECTORS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        op_valid,
    input  logic [16:0] dut_result,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] error_count,
    output logic        fail_seen,
    output logic [15:0] first_fail_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [15:0] SEED_A = 16'hACE1;
    localparam logic [15:0] SEED_B = 16'h1D0F;

    state_t      state_q, state_d;
    logic [15:0] opA_q, opA_d, opB_q, opB_d;
    logic        opValid_q, opValid_d;
    logic [15:0] opIdx_q, opIdx_d;
    logic [16:0] issueCnt_q, issueCnt_d;
    logic [15:0] lfsrA_q, lfsrA_d, lfsrB_q, lfsrB_d;
    logic [3:0]  drainCnt_q, drainCnt_d;
    logic [15:0] errCnt_q, errCnt_d;
    logic        failSeen_q, failSeen_d;
    logic [15:0] firstFailIdx_q, firstFailIdx_d;

    logic        clearLine;
    logic        issue;
    logic        abortNow;
    logic [15:0] vecIdx;
    logic [16:0] headRef;
    logic        tailValid;
    logic [16:0] tailRef;
    logic [15:0] tailIdx;

    // Fibonacci LFSR, taps 16/14/13/11, shifting toward bit 0
    function automatic logic [15:0] lfsrNext(input logic [15:0] s);
        lfsrNext = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    assign headRef = {1'b0, opA_q} + {1'b0, opB_q};

    // The reference travels beside the vector index so a mismatch can name its vector
    if (LATENCY == 0) begin : gNoDelay
        assign tailValid = opValid_q;
        assign tailRef   = headRef;
        assign tailIdx   = opIdx_q;
    end else begin : gDelay
        logic [LATENCY-1:0]       dlValid_q;
        logic [LATENCY-1:0][16:0] dlRef_q;
        logic [LATENCY-1:0][15:0] dlIdx_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dlValid_q <= '0;
                dlRef_q   <= '0;
                dlIdx_q   <= '0;
            end else begin
                dlValid_q[0] <= opValid_q && !clearLine;
                dlRef_q[0]   <= headRef;
                dlIdx_q[0]   <= opIdx_q;
                for (int i = 1; i < LATENCY; i++) begin
                    dlValid_q[i] <= dlValid_q[i-1] && !clearLine;
                    dlRef_q[i]   <= dlRef_q[i-1];
                    dlIdx_q[i]   <= dlIdx_q[i-1];
                end
            end
        end

        assign tailValid = dlValid_q[LATENCY-1];
        assign tailRef   = dlRef_q[LATENCY-1];
        assign tailIdx   = dlIdx_q[LATENCY-1];
    end

    assign abortNow = abort && (state_q != IDLE);

    always_comb begin
        state_d        = state_q;
        opA_d          = opA_q;
        opB_d          = opB_q;
        opValid_d      = 1'b0;
        opIdx_d        = opIdx_q;
        issueCnt_d     = issueCnt_q;
        lfsrA_d        = lfsrA_q;
        lfsrB_d        = lfsrB_q;
        drainCnt_d     = drainCnt_q;
        errCnt_d       = errCnt_q;
        failSeen_d     = failSeen_q;
        firstFailIdx_d = firstFailIdx_q;
        clearLine      = 1'b0;
        issue          = 1'b0;
        vecIdx         = issueCnt_q[15:0];

        if (abortNow) begin
            state_d   = IDLE;
            clearLine = 1'b1;
        end else begin
            if (tailValid && (dut_result !== tailRef)) begin
                if (errCnt_q != 16'hFFFF) begin
                    errCnt_d = errCnt_q + 16'd1;
                end
                if (!failSeen_q) begin
                    failSeen_d     = 1'b1;
                    firstFailIdx_d = tailIdx;
                end
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d        = RUN;
                        errCnt_d       = '0;
                        failSeen_d     = 1'b0;
                        firstFailIdx_d = '0;
                        lfsrA_d        = SEED_A;
                        lfsrB_d        = SEED_B;
                        issue          = 1'b1;
                        vecIdx         = '0;
                        issueCnt_d     = 17'd1;
                    end
                end
                RUN: begin
                    // One idle cycle after the last vector keeps busy up to the final compare
                    if (issueCnt_q < 17'(NUM_VECTORS)) begin
                        issue      = 1'b1;
                        issueCnt_d = issueCnt_q + 17'd1;
                    end else if (!opValid_q) begin
                        state_d    = (LATENCY == 0) ? DONE : DRAIN;
                        drainCnt_d = '0;
                    end
                end
                DRAIN: begin
                    if (drainCnt_q == 4'(LATENCY - 1)) begin
                        state_d = DONE;
                    end else begin
                        drainCnt_d = drainCnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (issue) begin
                opValid_d = 1'b1;
                opIdx_d   = vecIdx;
                case (vecIdx)
                    16'd0: begin opA_d = 16'h0000; opB_d = 16'h0000; end
                    16'd1: begin opA_d = 16'hFFFF; opB_d = 16'hFFFF; end
                    16'd2: begin opA_d = 16'hFFFF; opB_d = 16'h0001; end
                    16'd3: begin opA_d = 16'h5555; opB_d = 16'hAAAA; end
                    default: begin
                        opA_d   = lfsrA_q;
                        opB_d   = lfsrB_q;
                        lfsrA_d = lfsrNext(lfsrA_q);
                        lfsrB_d = lfsrNext(lfsrB_q);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            opA_q          <= '0;
            opB_q          <= '0;
            opValid_q      <= 1'b0;
            opIdx_q        <= '0;
            issueCnt_q     <= '0;
            lfsrA_q        <= SEED_A;
            lfsrB_q        <= SEED_B;
            drainCnt_q     <= '0;
            errCnt_q       <= '0;
            failSeen_q     <= 1'b0;
            firstFailIdx_q <= '0;
        end else begin
            state_q        <= state_d;
            opA_q          <= opA_d;
            opB_q          <= opB_d;
            opValid_q      <= opValid_d;
            opIdx_q        <= opIdx_d;
            issueCnt_q     <= issueCnt_d;
            lfsrA_q        <= lfsrA_d;
            lfsrB_q        <= lfsrB_d;
            drainCnt_q     <= drainCnt_d;
            errCnt_q       <= errCnt_d;
            failSeen_q     <= failSeen_d;
            firstFailIdx_q <= firstFailIdx_d;
        end
    end

    assign op_a           = opA_q;
    assign op_b           = opB_q;
    assign op_valid       = opValid_q;
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign pass           = (state_q == DONE) && (errCnt_q == 16'd0);
    assign error_count    = errCnt_q;
    assign fail_seen      = failSeen_q;
    assign first_fail_idx = firstFailIdx_q;

endmodule
